// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle, results delivered as a registered write-back triple for the bank.
module unidad_muldiv #(
  parameter int ANCHO = 32,
  parameter int N     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [ANCHO-1:0] rs1,
  input  logic [ANCHO-1:0] rs2,
  input  logic [N-1:0]     rd_in,
  output logic             busy,
  output logic             done,
  output logic [ANCHO-1:0] result,
  output logic [N-1:0]     rd_out,
  output logic             we
);

  localparam int W = ANCHO;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic           sa_q, sa_d, sb_q, sb_d;
  logic           spec_q, spec_d;
  logic [N-1:0]   rd_q, rd_d;

  logic           busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [W-1:0]   result_q, result_d;
  logic [N-1:0]   rd_out_q, rd_out_d;

  // Capture-time decode of the incoming request.
  logic         a_signed, b_signed, sa_in, sb_in;
  logic [W-1:0] mag_a, mag_b, spec_val;
  logic         div_zero, div_ovf;

  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sa_in    = a_signed & rs1[W-1];
  assign sb_in    = b_signed & rs2[W-1];
  assign mag_a    = sa_in ? -rs1 : rs1;
  assign mag_b    = sb_in ? -rs2 : rs2;
  assign div_zero = funct3[2] && (rs2 == '0);
  assign div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                    (rs1 == {1'b1, {(W-1){1'b0}}}) && (rs2 == '1);

  always_comb begin
    spec_val = '0;
    if (div_zero)     spec_val = funct3[1] ? rs1 : '1;
    else if (div_ovf) spec_val = funct3[1] ? '0 : rs1;
  end

  // One iteration step; the product register doubles as {remainder, quotient}.
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W+1:0] div_trial;

  assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = prod_q[2*W-1:W-1];
  assign div_trial = {1'b0, div_shift} - {2'b00, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    b_d     = b_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    spec_d  = spec_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d    = mag_b;
          op_d   = funct3;
          sa_d   = sa_in;
          sb_d   = sb_in;
          rd_d   = rd_in;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            spec_d  = 1'b1;
            prod_d  = {{W{1'b0}}, spec_val};
            state_d = FIN;
          end else begin
            spec_d  = 1'b0;
            prod_d  = {{W{1'b0}}, mag_a};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (!div_trial[W+1]) prod_d = {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
          else                 prod_d = {div_shift[W-1:0], prod_q[W-2:0], 1'b0};
        end else begin
          prod_d = {mul_sum, prod_q[W-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(W - 1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign correction applied to the final datapath value on entry to FIN.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fin_val;

  assign prod_fix = (sa_d ^ sb_d) ? -prod_d : prod_d;

  always_comb begin
    fin_val = '0;
    if (spec_d)            fin_val = prod_d[W-1:0];
    else if (!op_d[2])     fin_val = (op_d[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    else if (!op_d[1])     fin_val = (sa_d ^ sb_d) ? -prod_d[W-1:0] : prod_d[W-1:0];
    else                   fin_val = sa_d ? -prod_d[2*W-1:W] : prod_d[2*W-1:W];
  end

  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN);
    result_d = done_d ? fin_val : result_q;
    rd_out_d = done_d ? rd_d : rd_out_q;
    we_d     = done_d && (rd_out_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // NOTE: operand/datapath registers carry no reset; they are always loaded
  // at capture before use, and leaving them out keeps the reset fan-out small.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    b_q    <= b_d;
    op_q   <= op_d;
    sa_q   <= sa_d;
    sb_q   <= sb_d;
    spec_q <= spec_d;
    rd_q   <= rd_d;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we     = we_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
